// File: rtl/ram_io_loader_pkg.sv
`default_nettype none
// ============================================================================
// nn_pkg : shared IO RAM geometry and loader state encoding
// Rev 1.0 : initial release
// ============================================================================
package nn_pkg;

  localparam int IO_ADDR_W = 10;
  localparam int IO_DATA_W = 16;
  localparam int IO_WORDS  = 784;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_io_loader_if.sv
`default_nettype none
// ============================================================================
// ram_io_loader_if : control, byte stream and RAM write bus of the IO loader
// Rev 1.0 : initial release
// ============================================================================
interface ram_io_loader_if
  import nn_pkg::*;
#(
  parameter int ADDR_W = IO_ADDR_W,
  parameter int DATA_W = IO_DATA_W
) ();

  logic              start;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] word_count;

  modport master (
    output start, abort, in_data, in_valid,
    input  in_ready, ram_a, ram_d, ram_we, busy, done, word_count
  );

  modport slave (
    input  start, abort, in_data, in_valid,
    output in_ready, ram_a, ram_d, ram_we, busy, done, word_count
  );

endinterface
`default_nettype wire

// File: rtl/ram_io_loader.sv
`default_nettype none
// ============================================================================
// ram_io_loader : packs a byte stream little-endian into 16-bit words and
//                 writes them to the IO RAM from address 0, then pulses done
// Rev 1.0 : initial release
// ============================================================================
module ram_io_loader
  import nn_pkg::*;
#(
  parameter int N_WORDS = IO_WORDS,
  parameter int ADDR_W  = IO_ADDR_W,
  parameter int DATA_W  = IO_DATA_W
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  ram_io_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N_WORDS - 1);

  loader_state_t     state_q, state_d;
  logic [7:0]        lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;

  assign accept = bus.in_valid && ready_q;

  // Abort wins over every other transition, including Start in IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = LO;
        LO:      if (accept) state_d = HI;
        HI:      if (accept) state_d = WR;
        WR:      state_d = (addr_q == LAST_A) ? DONE : LO;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they are pure Moore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LO) || (state_d == HI);
      we_q    <= (state_d == WR);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (bus.abort) begin
        lo_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              addr_q <= '0;
              wcnt_q <= '0;
            end
          end
          LO: if (accept) lo_q <= bus.in_data;
          HI: if (accept) wdata_q <= DATA_W'({bus.in_data, lo_q});
          WR: begin
            wcnt_q <= wcnt_q + 1'b1;
            if (addr_q != LAST_A) addr_q <= addr_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.ram_a      = addr_q;
  assign bus.ram_d      = wdata_q;
  assign bus.ram_we     = we_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_count = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_io_loader.sv
`default_nettype none
// ============================================================================
// tb_ram_io_loader : table vectors plus randomized loads against a byte-stream
//                    reference model, on a 784-word and a 4-word instance
// Rev 1.0 : initial release
// ============================================================================
module tb_ram_io_loader;
  import nn_pkg::*;

  localparam int NF = IO_WORDS;
  localparam int NS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_io_loader_if #(.ADDR_W(IO_ADDR_W), .DATA_W(IO_DATA_W)) bf ();
  ram_io_loader_if #(.ADDR_W(IO_ADDR_W), .DATA_W(IO_DATA_W)) bs ();

  ram_io_loader #(.N_WORDS(NF), .ADDR_W(IO_ADDR_W), .DATA_W(IO_DATA_W)) u_full (
    .clk(clk), .rst_n(rst_n), .bus(bf.slave));
  ram_io_loader #(.N_WORDS(NS), .ADDR_W(IO_ADDR_W), .DATA_W(IO_DATA_W)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(bs.slave));

  logic [1:0] start_s = '0, abort_s = '0, valid_s = '0;
  logic [7:0] data_s [2];
  logic [1:0] rdy, we, busy, done;
  logic [9:0] ra [2];
  logic [9:0] wc [2];
  logic [15:0] rd [2];

  assign bf.start = start_s[0];  assign bs.start = start_s[1];
  assign bf.abort = abort_s[0];  assign bs.abort = abort_s[1];
  assign bf.in_valid = valid_s[0]; assign bs.in_valid = valid_s[1];
  assign bf.in_data = data_s[0]; assign bs.in_data = data_s[1];
  assign rdy  = {bs.in_ready, bf.in_ready};
  assign we   = {bs.ram_we, bf.ram_we};
  assign busy = {bs.busy, bf.busy};
  assign done = {bs.done, bf.done};
  assign ra[0] = bf.ram_a;      assign ra[1] = bs.ram_a;
  assign wc[0] = bf.word_count; assign wc[1] = bs.word_count;
  assign rd[0] = bf.ram_d;      assign rd[1] = bs.ram_d;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt [2];
  int done_cyc [2];
  int viol [2];
  logic [25:0] wlog0 [$];
  logic [25:0] wlog1 [$];
  logic [7:0] src [2048];

  typedef struct packed {
    logic       st, ab, vl;
    logic [7:0] dat;
    logic       rdy, busy, we, done;
    logic [9:0] ra, wc;
    logic [15:0] rd;
  } vec_t;
  vec_t tbl [12];

  always @(posedge clk) cyc++;

  // Record every RAM write and done pulse; flag ready outside LO/HI.
  always @(negedge clk) begin
    if (we[0]) wlog0.push_back({ra[0], rd[0]});
    if (we[1]) wlog1.push_back({ra[1], rd[1]});
    for (int d = 0; d < 2; d++) begin
      if (done[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (rdy[d] && (we[d] || !busy[d])) viol[d]++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    start_cyc  = cyc;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic feed(input int d, input int first, input int n, input bit rnd);
    int i = first;
    int guard = 0;
    while (i < first + n && guard < 40 * n + 100) begin
      valid_s[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_s[d]  = valid_s[d] ? src[i] : 8'($urandom);
      @(negedge clk);
      if (valid_s[d] && rdy[d]) i++;
      tick();
      guard++;
    end
    valid_s[d] = 1'b0;
    chk("feed_complete", 64'(i), 64'(first + n));
  endtask

  task automatic wait_done(input int d, input int budget, input string name);
    int n0 = done_cnt[d];
    int k  = 0;
    while (done_cnt[d] == n0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(done_cnt[d] - n0), 64'd1);
  endtask

  // Model: word j of a load is {byte 2j+1, byte 2j} of the stream, at address j.
  task automatic check_writes(input int d, input int nw, input string name);
    int sz = (d == 0) ? wlog0.size() : wlog1.size();
    int bad = 0, first_bad = -1;
    logic [25:0] e, x, e_bad, x_bad;
    chk({name, "_nwrites"}, 64'(sz), 64'(nw));
    for (int j = 0; j < nw && j < sz; j++) begin
      e = (d == 0) ? wlog0[j] : wlog1[j];
      x = {10'(j), src[2*j+1], src[2*j]};
      if (e !== x) begin
        if (bad == 0) begin first_bad = j; e_bad = e; x_bad = x; end
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_data: %0d words wrong, first word %0d got A/D 0x%07h expected 0x%07h",
               name, bad, first_bad, e_bad, x_bad);
    end
  endtask

  task automatic full_load(input string name);
    logic [25:0] e;
    for (int i = 0; i < 2 * NF; i++) src[i] = 8'(i);
    wlog0.delete();
    pulse_start(0);
    feed(0, 0, 2 * NF, 1'b0);
    wait_done(0, 50, {name, "_done"});
    check_writes(0, NF, name);
    e = (wlog0.size() > 0) ? wlog0[0] : '1;
    chk({name, "_first_write"}, 64'(e), {38'd0, 10'd0, 16'h0100});
    e = (wlog0.size() >= NF) ? wlog0[NF-1] : '1;
    chk({name, "_last_write"}, 64'(e), {38'd0, 10'd783, 16'h1F1E});
    chk({name, "_done_cycle"}, 64'(done_cyc[0] - start_cyc + 1), 64'd2354);
    chk({name, "_done_single"}, 64'(done[0]), 64'd0);
    chk({name, "_busy_after"}, 64'(busy[0]), 64'd0);
    chk({name, "_word_count"}, 64'(wc[0]), 64'd784);
    chk({name, "_final_addr"}, 64'(ra[0]), 64'd783);
  endtask

  initial begin
    int n0;
    data_s[0] = '0; data_s[1] = '0;
    for (int d = 0; d < 2; d++) begin done_cnt[d] = 0; done_cyc[d] = 0; viol[d] = 0; end

    // inputs -> outputs one cycle later, on the 4-word instance
    tbl[0]  = '{st:0, ab:0, vl:0, dat:8'h00, rdy:0, busy:0, we:0, done:0, ra:0, wc:0, rd:16'h0000};
    tbl[1]  = '{st:1, ab:1, vl:1, dat:8'h11, rdy:0, busy:0, we:0, done:0, ra:0, wc:0, rd:16'h0000};
    tbl[2]  = '{st:1, ab:0, vl:1, dat:8'h22, rdy:1, busy:1, we:0, done:0, ra:0, wc:0, rd:16'h0000};
    tbl[3]  = '{st:0, ab:0, vl:1, dat:8'hAA, rdy:1, busy:1, we:0, done:0, ra:0, wc:0, rd:16'h0000};
    tbl[4]  = '{st:0, ab:0, vl:0, dat:8'h55, rdy:1, busy:1, we:0, done:0, ra:0, wc:0, rd:16'h0000};
    tbl[5]  = '{st:1, ab:0, vl:1, dat:8'hBB, rdy:0, busy:1, we:1, done:0, ra:0, wc:0, rd:16'hBBAA};
    tbl[6]  = '{st:0, ab:0, vl:1, dat:8'hCC, rdy:1, busy:1, we:0, done:0, ra:1, wc:1, rd:16'hBBAA};
    tbl[7]  = '{st:0, ab:0, vl:1, dat:8'h12, rdy:1, busy:1, we:0, done:0, ra:1, wc:1, rd:16'hBBAA};
    tbl[8]  = '{st:0, ab:1, vl:1, dat:8'h34, rdy:0, busy:0, we:0, done:0, ra:1, wc:1, rd:16'hBBAA};
    tbl[9]  = '{st:0, ab:0, vl:1, dat:8'h56, rdy:0, busy:0, we:0, done:0, ra:1, wc:1, rd:16'hBBAA};
    tbl[10] = '{st:1, ab:0, vl:0, dat:8'h00, rdy:1, busy:1, we:0, done:0, ra:0, wc:0, rd:16'hBBAA};
    tbl[11] = '{st:0, ab:1, vl:0, dat:8'h00, rdy:0, busy:0, we:0, done:0, ra:0, wc:0, rd:16'hBBAA};

    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_outs_%0d", d),
          {rdy[d], busy[d], we[d], done[d], ra[d], wc[d], rd[d]}, 64'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 12; v++) begin
      start_s[1] = tbl[v].st; abort_s[1] = tbl[v].ab;
      valid_s[1] = tbl[v].vl; data_s[1]  = tbl[v].dat;
      tick();
      chk($sformatf("table_vec_%0d", v),
          {rdy[1], busy[1], we[1], done[1], ra[1], wc[1], rd[1]},
          {tbl[v].rdy, tbl[v].busy, tbl[v].we, tbl[v].done, tbl[v].ra, tbl[v].wc, tbl[v].rd});
    end
    start_s[1] = 0; abort_s[1] = 0; valid_s[1] = 0;
    tick();

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2 * NS; i++) src[i] = 8'($urandom);
      wlog1.delete();
      viol[1] = 0;
      pulse_start(1);
      feed(1, 0, 2 * NS, 1'b1);
      wait_done(1, 50, "rnd_done");
      check_writes(1, NS, "rnd");
      chk("rnd_handshake", 64'(viol[1]), 64'd0);
      chk("rnd_word_count", 64'(wc[1]), 64'd4);
    end

    // Start pulsed in HI and again in WR must not restart the load.
    for (int i = 0; i < 2 * NS; i++) src[i] = 8'(8'h40 + i);
    wlog1.delete();
    n0 = done_cnt[1];
    pulse_start(1);
    valid_s[1] = 1; data_s[1] = src[0]; tick();
    data_s[1] = src[1]; start_s[1] = 1; tick();
    valid_s[1] = 0; tick();
    start_s[1] = 0;
    feed(1, 2, 2 * NS - 2, 1'b0);
    wait_done(1, 50, "restart_done");
    repeat (4) tick();
    check_writes(1, NS, "restart");
    chk("restart_done_count", 64'(done_cnt[1] - n0), 64'd1);

    full_load("full");

    // Abort while waiting for the high byte of word 10.
    wlog0.delete();
    n0 = done_cnt[0];
    pulse_start(0);
    feed(0, 0, 21, 1'b0);
    abort_s[0] = 1; tick(); abort_s[0] = 0;
    chk("abort_hi_idle", {busy[0], rdy[0]}, 64'd0);
    repeat (5) tick();
    check_writes(0, 10, "abort_hi");
    chk("abort_hi_no_done", 64'(done_cnt[0] - n0), 64'd0);
    chk("abort_hi_word_count", 64'(wc[0]), 64'd10);
    full_load("reload");

    // Abort during the write cycle of word 5.
    wlog0.delete();
    n0 = done_cnt[0];
    pulse_start(0);
    feed(0, 0, 12, 1'b0);
    abort_s[0] = 1;
    @(negedge clk);
    chk("abort_wr_we", {we[0], ra[0]}, {1'b1, 10'd5});
    tick(); abort_s[0] = 0;
    chk("abort_wr_idle", 64'(busy[0]), 64'd0);
    chk("abort_wr_word_count", 64'(wc[0]), 64'd5);
    repeat (3) tick();
    check_writes(0, 6, "abort_wr");
    chk("abort_wr_no_done", 64'(done_cnt[0] - n0), 64'd0);

    // Asynchronous reset in the middle of a cycle during a load.
    wlog0.delete();
    pulse_start(0);
    feed(0, 0, 101, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outs", {rdy[0], busy[0], we[0], done[0], ra[0], wc[0], rd[0]}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    full_load("post_reset");

    chk("handshake_full", 64'(viol[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
